// File: rtl/cfg_chain_pkg.sv
// ---------------------------------------------------------------------------
// cfg_chain_pkg
// Shared types and helpers for the configuration scan chain:
//   - cfg_state_t : load sequencer states
//   - beats()     : number of scan beats in one full load
//   - cnt_width() : width of the beat counter
// ---------------------------------------------------------------------------
package cfg_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } cfg_state_t;

    function automatic int beats(input int width, input int lanes);
        return width / lanes;
    endfunction

    // A full load is always at least two beats, so one bit is the floor.
    function automatic int cnt_width(input int width, input int lanes);
        int n;
        n = width / lanes;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_chain_ctrl.sv
// ---------------------------------------------------------------------------
// cfg_chain_ctrl
// Load sequencer for the configuration scan chain: FSM plus beat counter.
// Optional parity check beat is built when CFG_PARITY_EN is defined.
// Ports:
//   i_ck, i_rst       clock (rising), async active-high reset
//   i_start           begin a new load (wins over i_se)
//   i_se              scan enable, one beat per cycle
//   i_par_bit         SI[0], parity bit sampled on the check beat
//   i_chain_par       even parity of the current chain contents
//   o_shift_en        chain shifts on this edge
//   o_load_last       this edge captures the final data beat
//   o_state           current sequencer state
//   o_busy/o_done/o_err  registered status flags
// ---------------------------------------------------------------------------
module cfg_chain_ctrl
    import cfg_chain_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  logic       i_ck,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_se,
    input  logic       i_par_bit,
    input  logic       i_chain_par,
    output logic       o_shift_en,
    output logic       o_load_last,
    output logic [2:0] o_state,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int             BEATS = beats(WIDTH, LANES);
    localparam int             CW    = cnt_width(WIDTH, LANES);
    localparam logic [CW-1:0]  LAST  = CW'(BEATS - 1);

    cfg_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          w_shift_en;
    logic          w_load_last;

    // A start pulse discards any beat presented in the same cycle.
    assign w_shift_en  = (r_state == ST_SHIFT) && i_se && !i_start;
    assign w_load_last = w_shift_en && (r_cnt == LAST);

`ifndef CFG_PARITY_EN
    logic w_unused_par;
    assign w_unused_par = i_par_bit ^ i_chain_par;
`endif

    // Sequencer state, beat counter and registered status flags.
    always_ff @(posedge i_ck or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_start) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (w_load_last) begin
                        r_cnt <= '0;
`ifdef CFG_PARITY_EN
                        r_state <= ST_CHECK;
`else
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else if (w_shift_en) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
`ifdef CFG_PARITY_EN
                ST_CHECK: begin
                    if (i_se) begin
                        r_busy <= 1'b0;
                        if (i_par_bit == i_chain_par) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_CHECK;
                    end
                end
`endif
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign o_shift_en  = w_shift_en;
    assign o_load_last = w_load_last;
    assign o_state     = r_state;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: rtl/cfg_scan_chain.sv
// ---------------------------------------------------------------------------
// cfg_scan_chain
// WIDTH-bit configuration scan chain shifting LANES bits per beat, with a
// load sequencer that releases the word on Q only after a complete load.
// Optional parity check beat: define CFG_PARITY_EN.
// Ports:
//   CK, RST     clock (rising), async active-high reset
//   CFG_START   begin a new load
//   SE, SI      scan enable / scan data in (LANES bits)
//   SO          chain tail for cascading into the next tile
//   CFGE, CFGQ  raw chain observe (zero when CFGE=0)
//   Q           released configuration word (zero unless DONE)
//   BUSY, DONE, ERR  sequencer status
// ---------------------------------------------------------------------------
module cfg_scan_chain
    import cfg_chain_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             CFG_START,
    input  logic             SE,
    input  logic [LANES-1:0] SI,
    output logic [LANES-1:0] SO,
    input  logic             CFGE,
    output logic [WIDTH-1:0] CFGQ,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    logic [WIDTH-1:0] r_chain;
    logic             w_shift_en;
    logic             w_load_last;
    logic [2:0]       w_state;
    logic             w_chain_par;
    logic             w_unused_last;

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    assign w_chain_par   = even_parity(r_chain);
    assign w_unused_last = w_load_last;

    cfg_chain_ctrl #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_ctrl (
        .i_ck        (CK),
        .i_rst       (RST),
        .i_start     (CFG_START),
        .i_se        (SE),
        .i_par_bit   (SI[0]),
        .i_chain_par (w_chain_par),
        .o_shift_en  (w_shift_en),
        .o_load_last (w_load_last),
        .o_state     (w_state),
        .o_busy      (BUSY),
        .o_done      (DONE),
        .o_err       (ERR)
    );

    // Chain register: first beat shifted in ends up at the top.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_chain <= '0;
        end else if (w_shift_en) begin
            r_chain <= {r_chain[WIDTH-LANES-1:0], SI};
        end else begin
            r_chain <= r_chain;
        end
    end

    assign SO   = r_chain[WIDTH-1 -: LANES];
    assign CFGQ = CFGE ? r_chain : '0;
    assign Q    = (w_state == ST_DONE) ? r_chain : '0;

endmodule

// File: doc/cfg_scan_chain.md
# cfg_scan_chain

Parametrised configuration scan chain with a load sequencer, used to hold the configuration bits of one FPGA tile. It generalises the single-bit scan/configure flip-flops into a WIDTH-bit chain that shifts LANES bits per beat. It counts beats, and releases the configuration word to the fabric only after a complete, optionally parity-checked load. Chains cascade tile-to-tile through SO to SI.

## Interface
Parameters:
- WIDTH, 32: configuration bits held; must be a multiple of LANES, ≥ 2·LANES.
- LANES, 1: scan bits shifted per beat (1, 2, 4, 8).

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- CFG_START  input  1  single-cycle pulse; begins a new load.
- SE  input  1  scan enable; one beat is accepted per cycle with SE=1 while loading.
- SI  input  LANES  scan data in.
- SO  output  LANES  chain tail (chain[WIDTH-1 -: LANES]), for cascading.
- CFGE  input  1  configure-observe enable.
- CFGQ  output  WIDTH  raw chain contents when CFGE=1, else all 0.
- Q  output  WIDTH  released configuration word; all 0 unless in DONE.
- BUSY  output  1  high in SHIFT and CHECK.
- DONE  output  1  high in DONE.
- ERR  output  1  high in ERROR.

## Operation
- States: IDLE, SHIFT, CHECK (exists only with CFG_PARITY_EN), DONE, ERROR.
- RST: state=IDLE, chain=0, beat counter=0. All outputs are 0, including SO, Q, CFGQ, BUSY, DONE and ERR.
- CFG_START in any state: next state is SHIFT and the counter clears. The chain is not cleared. Q drops to 0 on the next cycle.
- CFG_START has priority over SE in the same cycle; that cycle's beat is discarded.
- In SHIFT with SE=1, the chain updates to {chain[WIDTH-LANES-1:0], SI} and the counter increments.
- The first beat shifted ends at the top of the chain. For LANES=1, send the word MSB first.
- SE=0 in SHIFT is a stall: chain and counter hold, with no timeout.
- Final beat (counter = WIDTH/LANES-1, SE=1): the chain shifts and the counter clears. Next state is DONE, or CHECK when parity is compiled in.
- CHECK: waits for SE=1, then compares SI[0] against the even parity of all WIDTH chain bits.
  - Match: next state is DONE. Mismatch: next state is ERROR.
  - SI[LANES-1:1] is ignored. The chain does not shift on the parity beat.
- IDLE, DONE and ERROR ignore SE. The chain is frozen and SO is stable.
- Q = chain in DONE, else 0.
- CFGQ = CFGE ? chain : 0, independent of state. This lets the chain be read back during shifting.
- ERROR holds (Q=0, ERR=1) until CFG_START or RST.

## Timing
- All state, chain and counter registers update on the CK rising edge. RST acts immediately.
- Outputs are decoded from registers; there is no combinational path from SI or SE to Q.
- SO and CFGQ follow the chain with zero extra latency.
- DONE and Q are valid in the cycle after the edge that captures the final beat, or the parity beat when parity is compiled in.
- Load length is WIDTH/LANES accepted beats, plus 1 with parity. Stall cycles add latency one-for-one.
- RST mid-load aborts the load: state=IDLE and chain=0 immediately, asynchronously.
- The counter is $clog2(WIDTH/LANES) bits wide and never wraps past the final beat.

## Configuration
- CFG_PARITY_EN defined: the CHECK state and the parity beat are present, and ERR can assert.
- Not defined: CHECK is absent and the final data beat goes directly to DONE. ERR is tied to 0, and ERROR is unreachable.

## Structure
- Package cfg_chain_pkg holds:
  - the state enum type (IDLE, SHIFT, CHECK, DONE, ERROR);
  - function beats(WIDTH, LANES) returning WIDTH/LANES;
  - the counter-width constant helper.
- Sub-module cfg_chain_ctrl holds the FSM and beat counter. It outputs shift_en, load_last, the state, and the BUSY/DONE/ERR flags.
- The top level holds the chain register, SO, and the Q/CFGQ gating.

## Test plan
- WIDTH=8, LANES=1, no parity: CFG_START, then 8 beats SE=1 with SI=1,0,1,0,0,1,0,1 → DONE=1 and Q=8'hA5 on the cycle after the 8th edge. BUSY falls on that same cycle.
- WIDTH=8, LANES=2: beats SI=2'b11,2'b00,2'b01,2'b10 → Q=8'hC6 after 4 beats. SO shows 2'b11 once the 4th beat is shifted.
- Stall: same as scenario 1 with SE=0 for 3 cycles after beat 4 → Q=8'hA5, DONE 3 cycles later than scenario 1, and no extra shifts.
- Restart and reset: CFG_START after beat 5 → counter restarts, so 8 more beats are needed for DONE. RST asserted mid-load → state IDLE, Q=0, CFGQ=0, SO=0 immediately.
- CFG_PARITY_EN, WIDTH=8, loading 8'hA5 (parity 0):
  - parity beat SI[0]=0 → DONE, Q=8'hA5.
  - parity beat SI[0]=1 → ERR=1, Q=0; then CFG_START → ERR=0, BUSY=1.
- CFGE: with CFGE=1 during shifting, CFGQ tracks the chain each beat. CFGE=0 → CFGQ=0 in every state.
